// File: rtl/ebr_block_reader.sv
// ebr_block_reader: read-side master for the dual-port EBR RAM.
// Streams a block of Length words starting at StartAddr, with address wrap at
// the end of the array, over a valid/ready interface backed by a 2-entry FIFO.
// The RAM has one cycle of read latency. Reads are credit-limited, so the FIFO
// never overflows.
// Optional byte-parity checking is enabled by defining EBR_READER_PARITY_CHECK_EN.
// When that macro is undefined, OutErr and ErrCount are tied to 0 and EDO is ignored.
module ebr_block_reader #(
    parameter int AW   = 10,
    parameter int DW   = 32,
    parameter int PW   = 4,
    parameter int ERRW = 8
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            Start,
    input  logic [AW-1:0]   StartAddr,
    input  logic [AW:0]     Length,
    output logic            Busy,
    output logic            Done,
    output logic [AW-1:0]   RdAddress,
    output logic            RdEn,
    input  logic [DW-1:0]   Q,
    input  logic [PW-1:0]   EDO,
    output logic [DW-1:0]   OutData,
    output logic            OutErr,
    output logic            OutLast,
    output logic            OutValid,
    input  logic            OutReady,
    output logic [ERRW-1:0] ErrCount
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

    state_t          state, state_nxt;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     issue_cnt;
    logic [AW:0]     acc_cnt;
    logic            rd_vld_p1;    // read issued last cycle, so Q/EDO are valid now
    logic            zero_done;    // Done pulse for a zero-length request
    logic [DW-1:0]   buf_data [2];
    logic            buf_wr;
    logic            buf_rd;
    logic [1:0]      buf_cnt;
    logic [1:0]      credit;
    logic            start_ok;
    logic            accept;
    logic            rd_en;

    assign start_ok = (state == IDLE) && Start && (Length != '0);
    assign accept   = OutValid && OutReady;
    // A slot freed by this cycle's accept may be reused by this cycle's read.
    assign credit   = buf_cnt + {1'b0, rd_vld_p1} - {1'b0, accept};

    // Next-state and read-issue decision
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_ok) state_nxt = RUN;
            end
            RUN: begin
                rd_en = (issue_cnt != '0) && (credit < 2'd2);
                if (rd_en && (issue_cnt == CNT_ONE)) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (acc_cnt == '0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, read pointer and block counters
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            issue_cnt <= '0;
            acc_cnt   <= '0;
            rd_vld_p1 <= 1'b0;
            zero_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            rd_vld_p1 <= rd_en;
            zero_done <= (state == IDLE) && Start && (Length == '0);
            if (start_ok) begin
                rd_ptr    <= StartAddr;
                issue_cnt <= Length;
                acc_cnt   <= Length;
            end else begin
                if (rd_en) begin
                    rd_ptr    <= rd_ptr + PTR_ONE;
                    issue_cnt <= issue_cnt - CNT_ONE;
                end
                if (accept) acc_cnt <= acc_cnt - CNT_ONE;
            end
        end
    end

    // Stage p1 -> output FIFO: capture RAM data one cycle after RdEn
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            buf_wr  <= 1'b0;
            buf_rd  <= 1'b0;
            buf_cnt <= 2'd0;
            for (int i = 0; i < 2; i++) buf_data[i] <= '0;
        end else begin
            if (rd_vld_p1) begin
                buf_data[buf_wr] <= Q;
                buf_wr           <= ~buf_wr;
            end
            if (accept) buf_rd <= ~buf_rd;
            buf_cnt <= buf_cnt + {1'b0, rd_vld_p1} - {1'b0, accept};
        end
    end

    assign RdEn      = rd_en;
    assign RdAddress = rd_ptr;
    assign Busy      = (state != IDLE);
    assign Done      = zero_done || ((state == DRAIN) && (acc_cnt == '0));
    assign OutValid  = (buf_cnt != 2'd0);
    assign OutData   = buf_data[buf_rd];
    // acc_cnt only moves on accept, so OutLast holds steady while stalled.
    assign OutLast   = OutValid && (acc_cnt == CNT_ONE);

`ifdef EBR_READER_PARITY_CHECK_EN
    localparam logic [ERRW-1:0] ERR_ONE = {{(ERRW-1){1'b0}}, 1'b1};

    logic            buf_err [2];
    logic [ERRW-1:0] err_cnt;

    // EDO[i] carries the even-parity bit of byte i; any byte disagreement flags the word.
    function automatic logic parity_err(input logic [DW-1:0] d, input logic [PW-1:0] p);
        logic [PW-1:0] calc;
        for (int i = 0; i < PW; i++) calc[i] = ^d[8*i +: 8];
        return |(calc ^ p);
    endfunction

    // Stage p1 -> output FIFO: parity flag stored alongside each captured word
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 2; i++) buf_err[i] <= 1'b0;
        end else if (rd_vld_p1) begin
            buf_err[buf_wr] <= parity_err(Q, EDO);
        end
    end

    // Saturating error count, cleared when a new block starts
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            err_cnt <= '0;
        end else if (start_ok) begin
            err_cnt <= '0;
        end else if (accept && buf_err[buf_rd] && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_ONE;
        end
    end

    assign OutErr   = OutValid && buf_err[buf_rd];
    assign ErrCount = err_cnt;
`else
    logic unused_edo;
    assign unused_edo = ^EDO;
    assign OutErr     = 1'b0;
    assign ErrCount   = '0;
`endif

endmodule

// File: tb/tb_ebr_block_reader.sv
// Self-checking bench for ebr_block_reader with a behavioural 1024x32+4 RAM
// and a scoreboard of expected output words.
module tb_ebr_block_reader;

`ifdef EBR_READER_PARITY_CHECK_EN
    localparam bit PARITY_ON = 1'b1;
`else
    localparam bit PARITY_ON = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        logic        last;
    } exp_t;

    logic        Clock;
    logic        Reset;
    logic        Start;
    logic [9:0]  StartAddr;
    logic [10:0] Length;
    logic        Busy;
    logic        Done;
    logic [9:0]  RdAddress;
    logic        RdEn;
    logic [31:0] Q;
    logic [3:0]  EDO;
    logic [31:0] OutData;
    logic        OutErr;
    logic        OutLast;
    logic        OutValid;
    logic        OutReady;
    logic [7:0]  ErrCount;

    logic [31:0] mem [1024];
    logic [3:0]  par [1024];
    exp_t        exp_q[$];
    int          bad_addr = -1;
    int          n_tests  = 0;
    int          n_fail   = 0;

    ebr_block_reader dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
        .Length(Length), .Busy(Busy), .Done(Done), .RdAddress(RdAddress),
        .RdEn(RdEn), .Q(Q), .EDO(EDO), .OutData(OutData), .OutErr(OutErr),
        .OutLast(OutLast), .OutValid(OutValid), .OutReady(OutReady),
        .ErrCount(ErrCount)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Behavioural RAM read port: one cycle latency, output holds when RdEn=0
    always @(posedge Clock) begin
        if (RdEn) begin
            Q   <= mem[RdAddress];
            EDO <= par[RdAddress];
        end
    end

    function automatic logic [3:0] gen_par(input logic [31:0] d);
        logic [3:0] p;
        for (int i = 0; i < 4; i++) p[i] = ^d[8*i +: 8];
        return p;
    endfunction

    task automatic push_block(input int addr, input int len);
        exp_t e;
        int   a;
        for (int i = 0; i < len; i++) begin
            a      = (addr + i) % 1024;
            e.data = mem[a];
            e.err  = PARITY_ON && (a == bad_addr);
            e.last = (i == len - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic start_block(input int addr, input int len);
        @(posedge Clock); #1;
        Start     = 1'b1;
        StartAddr = addr[9:0];
        Length    = len[10:0];
        @(posedge Clock); #1;
        Start     = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Start = 1'b0; StartAddr = '0; Length = '0; OutReady = 1'b0;
        repeat (3) @(negedge Clock);
        n_tests++; if ({Busy, Done, RdEn, OutValid, OutLast, OutErr} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctrl got %b want 000000", {Busy, Done, RdEn, OutValid, OutLast, OutErr}); end
        n_tests++; if (RdAddress !== 10'd0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", RdAddress); end
        n_tests++; if (OutData !== 32'd0) begin n_fail++; $display("FAIL reset_data got %0h want 0", OutData); end
        n_tests++; if (ErrCount !== 8'd0) begin n_fail++; $display("FAIL reset_errcnt got %0d want 0", ErrCount); end
        Reset = 1'b0;
        repeat (2) @(negedge Clock);
        n_tests++; if ({Busy, RdEn, OutValid} !== 3'b0) begin
            n_fail++; $display("FAIL reset_idle got %b want 000", {Busy, RdEn, OutValid}); end
    endtask

    task automatic test_basic();
        exp_t e;
        int cyc, first_rd, first_acc, prev_acc, done_cyc, nacc;
        OutReady = 1'b1;
        push_block(5, 4);
        start_block(5, 4);
        first_rd = -1; first_acc = -1; prev_acc = -1; done_cyc = -1; nacc = 0;
        for (cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
            @(negedge Clock); #1;
            if (RdEn && first_rd < 0) first_rd = cyc;
            if (OutValid && OutReady) begin
                n_tests++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL basic_extra got %0h want none", OutData); end
                else begin
                    e = exp_q.pop_front();
                    if (OutData !== e.data || OutLast !== e.last || OutErr !== e.err) begin
                        n_fail++; $display("FAIL basic_word got %0h/%b/%b want %0h/%b/%b",
                                           OutData, OutLast, OutErr, e.data, e.last, e.err); end
                    if (prev_acc >= 0) begin
                        n_tests++; if (cyc != prev_acc + 1) begin
                            n_fail++; $display("FAIL basic_gap got cycle %0d want %0d", cyc, prev_acc + 1); end
                    end else first_acc = cyc;
                    prev_acc = cyc; nacc++;
                end
            end
            if (Done) done_cyc = cyc;
        end
        n_tests++; if (nacc != 4) begin n_fail++; $display("FAIL basic_count got %0d want 4", nacc); end
        n_tests++; if (first_acc != first_rd + 2) begin
            n_fail++; $display("FAIL basic_latency got %0d want %0d", first_acc - first_rd, 2); end
        n_tests++; if (done_cyc != prev_acc + 1) begin
            n_fail++; $display("FAIL basic_done got cycle %0d want %0d", done_cyc, prev_acc + 1); end
        @(negedge Clock); #1;
        n_tests++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy got %b want 0", Busy); end
        n_tests++; if (ErrCount !== 8'd0) begin n_fail++; $display("FAIL basic_errcnt got %0d want 0", ErrCount); end
    endtask

    task automatic test_wrap();
        exp_t e;
        int exp_addr[$];
        int cyc, done_cyc, nacc, ea;
        exp_addr = '{1022, 1023, 0, 1};
        OutReady = 1'b1;
        push_block(1022, 4);
        start_block(1022, 4);
        done_cyc = -1; nacc = 0;
        for (cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
            @(negedge Clock); #1;
            if (RdEn) begin
                n_tests++;
                if (exp_addr.size() == 0) begin n_fail++; $display("FAIL wrap_extra_read got %0d want none", RdAddress); end
                else begin
                    ea = exp_addr.pop_front();
                    if (RdAddress !== ea[9:0]) begin n_fail++; $display("FAIL wrap_addr got %0d want %0d", RdAddress, ea); end
                end
            end
            if (OutValid && OutReady) begin
                n_tests++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL wrap_extra got %0h want none", OutData); end
                else begin
                    e = exp_q.pop_front(); nacc++;
                    if (OutData !== e.data || OutLast !== e.last) begin
                        n_fail++; $display("FAIL wrap_word got %0h/%b want %0h/%b", OutData, OutLast, e.data, e.last); end
                end
            end
            if (Done) done_cyc = cyc;
        end
        n_tests++; if (done_cyc < 0 || nacc != 4) begin
            n_fail++; $display("FAIL wrap_done got %0d words want 4 (done cycle %0d)", nacc, done_cyc); end
    endtask

    task automatic test_backpressure();
        exp_t e;
        logic pat [6];
        logic held;
        logic [31:0] held_data;
        int cyc, k, done_cyc, nacc, issued, accepted;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        OutReady = 1'b1;
        push_block(100, 6);
        start_block(100, 6);
        held = 1'b0; held_data = '0; k = 0; done_cyc = -1; nacc = 0; issued = 0; accepted = 0;
        for (cyc = 1; cyc <= 80 && done_cyc < 0; cyc++) begin
            @(negedge Clock);
            OutReady = pat[k % 6]; k++;
            #1;
            if (held) begin
                n_tests++; if (OutValid !== 1'b1 || OutData !== held_data) begin
                    n_fail++; $display("FAIL bp_stable got %b/%0h want 1/%0h", OutValid, OutData, held_data); end
            end
            issued += int'(RdEn);
            if (OutValid && OutReady) begin
                accepted++;
                n_tests++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL bp_extra got %0h want none", OutData); end
                else begin
                    e = exp_q.pop_front(); nacc++;
                    if (OutData !== e.data || OutLast !== e.last) begin
                        n_fail++; $display("FAIL bp_word got %0h/%b want %0h/%b", OutData, OutLast, e.data, e.last); end
                end
            end
            if (issued - accepted > 2) begin
                n_tests++; n_fail++; $display("FAIL bp_outstanding got %0d want <=2", issued - accepted);
            end
            held = OutValid && !OutReady;
            held_data = OutData;
            if (Done) done_cyc = cyc;
        end
        n_tests++; if (nacc != 6 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL bp_count got %0d words want 6", nacc); end
        n_tests++; if (issued != 6) begin n_fail++; $display("FAIL bp_reads got %0d want 6", issued); end
        OutReady = 1'b1;
    endtask

    task automatic test_parity();
        exp_t e;
        int cyc, done_cyc, nacc;
        bad_addr = 3;
        par[3] = gen_par(mem[3]) ^ 4'b0100;
        OutReady = 1'b1;
        push_block(0, 8);
        start_block(0, 8);
        done_cyc = -1; nacc = 0;
        for (cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
            @(negedge Clock); #1;
            if (OutValid && OutReady) begin
                n_tests++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL par_extra got %0h want none", OutData); end
                else begin
                    e = exp_q.pop_front(); nacc++;
                    if (OutData !== e.data || OutErr !== e.err || OutLast !== e.last) begin
                        n_fail++; $display("FAIL par_word got %0h/err%b want %0h/err%b", OutData, OutErr, e.data, e.err); end
                end
            end
            if (Done) done_cyc = cyc;
        end
        n_tests++; if (done_cyc < 0 || nacc != 8) begin n_fail++; $display("FAIL par_done got %0d words want 8", nacc); end
        @(negedge Clock); #1;
        n_tests++; if (ErrCount !== 8'(PARITY_ON)) begin
            n_fail++; $display("FAIL par_errcnt got %0d want %0d", ErrCount, PARITY_ON); end
    endtask

    task automatic test_len0();
        start_block(7, 0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge Clock); #1;
            n_tests++; if (Done !== (c == 1)) begin n_fail++; $display("FAIL len0_done cycle %0d got %b want %b", c, Done, c == 1); end
            n_tests++; if (Busy !== 1'b0 || RdEn !== 1'b0) begin
                n_fail++; $display("FAIL len0_idle cycle %0d got busy%b rden%b want 0 0", c, Busy, RdEn); end
        end
    endtask

    task automatic test_ignore_start();
        exp_t e;
        int cyc, done_cyc, nacc;
        OutReady = 1'b0;
        push_block(10, 3);
        start_block(10, 3);
        repeat (3) @(negedge Clock);
        Start = 1'b1; StartAddr = 10'd200; Length = 11'd5;
        #1;
        n_tests++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL ign_busy got %b want 1", Busy); end
        @(negedge Clock);
        Start = 1'b0; OutReady = 1'b1;
        done_cyc = -1; nacc = 0;
        for (cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
            #1;
            if (OutValid && OutReady) begin
                n_tests++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL ign_extra got %0h want none", OutData); end
                else begin
                    e = exp_q.pop_front(); nacc++;
                    if (OutData !== e.data || OutLast !== e.last) begin
                        n_fail++; $display("FAIL ign_word got %0h want %0h", OutData, e.data); end
                end
            end
            if (Done) done_cyc = cyc;
            @(negedge Clock);
        end
        n_tests++; if (done_cyc < 0 || nacc != 3) begin n_fail++; $display("FAIL ign_count got %0d want 3", nacc); end
        for (int c = 0; c < 6; c++) begin
            #1;
            n_tests++; if (RdEn !== 1'b0 || OutValid !== 1'b0 || Busy !== 1'b0) begin
                n_fail++; $display("FAIL ign_after got rden%b vld%b busy%b want 0 0 0", RdEn, OutValid, Busy); end
            @(negedge Clock);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int cyc, done_cyc, nacc;
        OutReady = 1'b1;
        push_block(2, 8);
        start_block(2, 8);
        nacc = 0;
        for (cyc = 1; cyc <= 40 && nacc < 2; cyc++) begin
            @(negedge Clock); #1;
            if (OutValid && OutReady) begin
                n_tests++;
                e = exp_q.pop_front(); nacc++;
                if (OutData !== e.data) begin n_fail++; $display("FAIL rm_word got %0h want %0h", OutData, e.data); end
            end
        end
        @(posedge Clock); #2;
        n_tests++; if (ErrCount !== 8'(PARITY_ON)) begin
            n_fail++; $display("FAIL rm_errcnt_pre got %0d want %0d", ErrCount, PARITY_ON); end
        Reset = 1'b1;
        #1;
        n_tests++; if ({Busy, Done, RdEn, OutValid, OutLast, OutErr} !== 6'b0 || OutData !== 32'd0
                       || RdAddress !== 10'd0 || ErrCount !== 8'd0) begin
            n_fail++; $display("FAIL rm_async got ctl%b data%0h addr%0d err%0d want 0",
                               {Busy, Done, RdEn, OutValid, OutLast, OutErr}, OutData, RdAddress, ErrCount); end
        exp_q.delete();
        @(negedge Clock);
        Reset = 1'b0;
        push_block(20, 3);
        start_block(20, 3);
        done_cyc = -1; nacc = 0;
        for (cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
            @(negedge Clock); #1;
            if (OutValid && OutReady) begin
                n_tests++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL rm2_extra got %0h want none", OutData); end
                else begin
                    e = exp_q.pop_front(); nacc++;
                    if (OutData !== e.data || OutLast !== e.last) begin
                        n_fail++; $display("FAIL rm2_word got %0h/%b want %0h/%b", OutData, OutLast, e.data, e.last); end
                end
            end
            if (Done) done_cyc = cyc;
        end
        n_tests++; if (done_cyc < 0 || nacc != 3) begin n_fail++; $display("FAIL rm2_count got %0d want 3", nacc); end
        n_tests++; if (ErrCount !== 8'd0) begin n_fail++; $display("FAIL rm2_errcnt got %0d want 0", ErrCount); end
    endtask

    initial begin
        for (int k = 0; k < 1024; k++) begin
            mem[k] = 32'(k);
            par[k] = gen_par(32'(k));
        end
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_parity();
        test_len0();
        test_ignore_start();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ebr_block_reader.md
Name: ebr_block_reader

Overview:
- Read-side master for the 1024x32+4 dual-port EBR RAM: drives RdAddress/RdEn, captures Q/EDO, checks byte parity, and streams words out over a valid/ready interface.
- Transfers a block of Length words starting at StartAddr, wrapping at the end of the array.
- Sits between the EBR read port and any downstream consumer (DMA, UART TX, bus bridge). The write port is owned by a separate writer block.

Parameters:
- AW, 10, RAM address width; depth is 2^AW
- DW, 32, data width (multiple of 8)
- PW, 4, parity width; must equal DW/8
- ERRW, 8, width of the saturating parity-error counter

Ports:
- Clock  in  1  system clock; also drives the RAM RdClock
- Reset  in  1  asynchronous, active-high reset
- Start  in  1  one-cycle pulse: begin block read (ignored while Busy=1)
- StartAddr  in  AW  first word address
- Length  in  AW+1  number of words, 0..2^AW
- Busy  out  1  high from the cycle after an accepted Start until Done
- Done  out  1  one-cycle pulse once the last word has been accepted downstream
- RdAddress  out  AW  RAM read address
- RdEn  out  1  RAM read enable; Q/EDO are valid the cycle after RdEn=1 and hold while RdEn=0
- Q  in  DW  RAM read data
- EDO  in  PW  RAM parity out; EDO[i] = even parity of Q[8i+7:8i]
- OutData  out  DW  streamed word
- OutErr  out  1  parity mismatch on OutData (sideband)
- OutLast  out  1  marks the final word of the block
- OutValid  out  1  OutData is valid
- OutReady  in  1  consumer accepts when OutValid&OutReady
- ErrCount  out  ERRW  saturating count of parity errors in the current/last block

Behaviour:
- Reset values: Busy=0, Done=0, RdEn=0, RdAddress=0, OutValid=0, OutLast=0, OutErr=0, OutData=0, ErrCount=0, FSM=IDLE. The output buffer is flushed and any in-flight read is discarded.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - Start=1 with Length!=0: load rd_ptr=StartAddr, issue_cnt=Length, acc_cnt=Length, clear ErrCount, then go to RUN.
  - Start=1 with Length=0: no reads; Done pulses the next cycle; stay in IDLE; Busy stays 0.
- RUN: each cycle, RdEn=1 if issue_cnt!=0 and (buffer occupancy + in-flight reads) < 2.
  - On RdEn: RdAddress=rd_ptr, rd_ptr increments modulo 2^AW (1023 -> 0 for AW=10), issue_cnt decrements.
  - When issue_cnt reaches 0, go to DRAIN.
- DRAIN: wait until acc_cnt=0, then pulse Done for one cycle and return to IDLE.
- Read latency:
  - RdEn high in cycle N: Q/EDO are sampled in cycle N+1 and written into a 2-entry output FIFO.
  - With OutReady held at 1, OutValid first rises in cycle N+2 after the first RdEn, and sustained throughput is 1 word/clock.
- Backpressure:
  - The credit rule ensures the FIFO never overflows and no RAM word is lost.
  - While OutValid=1 and OutReady=0, OutData, OutErr and OutLast hold stable.
- acc_cnt decrements on each OutValid&OutReady. OutLast=1 on the word accepted when acc_cnt=1.
- Parity:
  - per byte, calc[i] = ^Q[8i+7:8i]; OutErr = |(calc ^ EDO) for that word.
  - ErrCount increments on each accepted word with OutErr=1 and saturates at 2^ERRW-1.
- Length=2^AW reads the whole array once, with wrap if StartAddr!=0.
- Start while Busy=1 is ignored; there is no queueing.
- Reset asserted mid-block returns all outputs to their reset values immediately, regardless of the clock.

Optional Feature:
- Macro EBR_READER_PARITY_CHECK_EN.
- Defined: parity checking, OutErr and ErrCount operate as described above.
- Undefined: EDO is ignored, the parity logic is removed, and OutErr and ErrCount are tied to 0. All other timing is identical.

Test Plan:
- RAM preloaded addr k = k with correct parity; StartAddr=5, Length=4, OutReady=1 -> OutData 5,6,7,8 on consecutive cycles; OutLast on 8; Done 1 cycle after the last accept; Busy=0 afterwards; ErrCount=0.
- Wrap: StartAddr=1022, Length=4 -> RdAddress sequence 1022,1023,0,1; OutData matches those words in order.
- Backpressure: Length=6, OutReady toggles 1,0,0,1,0,1... -> all 6 words delivered once, in order, with no loss or duplication; OutData stable while stalled; at most 2 reads outstanding.
- Parity: word at addr 3 stored with EDO[2] flipped; read 0..7 -> OutErr=1 only on word 3; ErrCount=1 (macro defined). With the macro undefined: OutErr=0 and ErrCount=0.
- Length=0 Start -> no RdEn, Done pulses the next cycle, Busy stays 0. A second Start issued while Busy is ignored.
- Reset asserted mid-block after 2 of 8 words -> outputs return to reset values asynchronously. A new Start after release works normally, with ErrCount=0.
